// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Start/busy/done handshake; results held in registers until the next operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH:0]   A,
  input  logic [WIDTH:0]   B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Diff,
  output logic             Borrow,
  output logic             Overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH:0]  a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            c_q, c_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic            accept, last, nb, sum, cout;

  // One full-adder cell: a + ~b + c.
  assign nb   = ~b_q[0];
  assign sum  = a_q[0] ^ nb ^ c_q;
  assign cout = (a_q[0] & nb) | (a_q[0] & c_q) | (nb & c_q);
  assign last = (cnt_q == CntW'(WIDTH));

  assign accept = start && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StShift;
          a_d     = A;
          b_d     = B;
          c_d     = ~Bin;
          cnt_d   = '0;
        end
      end
      StShift: begin
        res_d = {sum, res_q[WIDTH:1]};
        a_d   = {1'b0, a_q[WIDTH:1]};
        b_d   = {1'b0, b_q[WIDTH:1]};
        c_d   = cout;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d  = StDone;
          diff_d   = {sum, res_q[WIDTH:1]};
          borrow_d = ~cout;
          // a_q[0]/b_q[0] hold the captured sign bits while processing the MSB.
          ovf_d    = (a_q[0] ^ b_q[0]) & (sum ^ a_q[0]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = (state_q == StDone);
  assign Diff     = diff_q;
  assign Borrow   = borrow_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4) against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset, start, Bin;
  logic [4:0] A, B;
  logic       busy, done, Borrow, Overflow;
  logic [4:0] Diff;

  int n_pass = 0;
  int n_total = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .busy     (busy),
    .done     (done),
    .Diff     (Diff),
    .Borrow   (Borrow),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, borrow, diff[4:0]} from plain integer arithmetic.
  function automatic logic [6:0] ref_sub(input int a, input int b, input int bin);
    int  d;
    logic bo, ov, sa, sb, sd;
    d  = (a - b - bin) & 31;
    bo = (a < b + bin);
    sa = (a >= 16);
    sb = (b >= 16);
    sd = (d >= 16);
    ov = (sa != sb) && (sd != sa);
    return {ov, bo, 5'(d)};
  endfunction

  // Issue one operation, scramble inputs after the accepting edge, wait (bounded) for done.
  task automatic run_op(input logic [4:0] op_a, input logic [4:0] op_b, input logic op_bin,
                        output int lat, output int busy_cnt, output logic [4:0] first_diff,
                        output logic diff_moved);
    @(negedge clk);
    A = op_a; B = op_b; Bin = op_bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 5'($urandom); B = 5'($urandom); Bin = 1'($urandom);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    first_diff = Diff;
    diff_moved = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (!done && Diff !== first_diff) diff_moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, Diff, Borrow, Overflow} !== 9'b0)
      $display("FAIL reset_state: got %b required 000000000",
               {busy, done, Diff, Borrow, Overflow});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc; logic [4:0] fd; logic mv;
    run_op(5'd9, 5'd3, 1'b0, lat, bc, fd, mv);
    n_total++;
    if (lat !== 5) $display("FAIL basic_latency: got %0d required 5", lat); else n_pass++;
    n_total++;
    if (bc !== 5) $display("FAIL basic_busy_cycles: got %0d required 5", bc); else n_pass++;
    n_total++;
    if ({Overflow, Borrow, Diff} !== 7'({1'b0, 1'b0, 5'd6}) || busy !== 1'b0)
      $display("FAIL basic_result: got ov=%b bo=%b diff=%0d busy=%b required 0 0 6 0",
               Overflow, Borrow, Diff, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: got done=%b required 0", done);
    else n_pass++;
  endtask

  task automatic test_borrow;
    int lat, bc; logic [4:0] fd; logic mv;
    run_op(5'd3, 5'd9, 1'b0, lat, bc, fd, mv);
    n_total++;
    if ({Overflow, Borrow, Diff} !== {1'b0, 1'b1, 5'd26})
      $display("FAIL borrow_3m9: got ov=%b bo=%b diff=%0d required 0 1 26",
               Overflow, Borrow, Diff);
    else n_pass++;
    run_op(5'd0, 5'd0, 1'b1, lat, bc, fd, mv);
    n_total++;
    if ({Borrow, Diff} !== {1'b1, 5'd31})
      $display("FAIL borrow_bin: got bo=%b diff=%0d required 1 31", Borrow, Diff);
    else n_pass++;
  endtask

  task automatic test_overflow;
    int lat, bc; logic [4:0] fd; logic mv;
    run_op(5'd15, 5'd16, 1'b0, lat, bc, fd, mv);
    n_total++;
    if ({Overflow, Borrow, Diff} !== {1'b1, 1'b1, 5'd31})
      $display("FAIL ovf_15m16: got ov=%b bo=%b diff=%0d required 1 1 31",
               Overflow, Borrow, Diff);
    else n_pass++;
    run_op(5'd16, 5'd1, 1'b0, lat, bc, fd, mv);
    n_total++;
    if ({Overflow, Borrow, Diff} !== {1'b1, 1'b0, 5'd15})
      $display("FAIL ovf_16m1: got ov=%b bo=%b diff=%0d required 1 0 15",
               Overflow, Borrow, Diff);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    A = 5'd9; B = 5'd3; Bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); A = 5'd1; B = 5'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    n_total++;
    if (lat !== 5 || Diff !== 5'd6)
      $display("FAIL ignore_start: got lat=%0d diff=%0d required 5 6", lat, Diff);
    else n_pass++;
    repeat (7) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ignore_not_queued: got busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    A = 5'd7; B = 5'd2; Bin = 1'b0; start = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    n_total++;
    if (lat !== 5 || Diff !== 5'd5)
      $display("FAIL b2b_first: got lat=%0d diff=%0d required 5 5", lat, Diff);
    else n_pass++;
    A = 5'd10; B = 5'd3;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_reaccept: got busy=%b done=%b required 1 0", busy, done);
    else n_pass++;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    n_total++;
    if (lat !== 5 || Diff !== 5'd7 || Borrow !== 1'b0)
      $display("FAIL b2b_second: got lat=%0d diff=%0d bo=%b required 5 7 0", lat, Diff, Borrow);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bc; logic [4:0] fd; logic mv; logic seen;
    @(negedge clk);
    A = 5'd3; B = 5'd9; Bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_total++;
    if ({busy, done, Diff, Borrow, Overflow} !== 9'b0)
      $display("FAIL reset_mid_state: got %b required 000000000",
               {busy, done, Diff, Borrow, Overflow});
    else n_pass++;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    n_total++;
    if (seen !== 1'b0) $display("FAIL reset_mid_no_done: got activity=%b required 0", seen);
    else n_pass++;
    run_op(5'd20, 5'd6, 1'b1, lat, bc, fd, mv);
    n_total++;
    if (lat !== 5 || Diff !== 5'd13 || Borrow !== 1'b0)
      $display("FAIL reset_mid_fresh: got lat=%0d diff=%0d bo=%b required 5 13 0",
               lat, Diff, Borrow);
    else n_pass++;
    // Reset beats start on the same edge.
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    n_total++;
    if (busy !== 1'b0 || Diff !== 5'd0)
      $display("FAIL reset_over_start: got busy=%b diff=%0d required 0 0", busy, Diff);
    else n_pass++;
  endtask

  task automatic test_exhaustive;
    int lat, bc, errs; logic [4:0] fd; logic mv; logic [6:0] exp_r, prev;
    int order[2048];
    for (int i = 0; i < 2048; i++) order[i] = i;
    for (int i = 2047; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    prev = '0;
    errs = 0;
    for (int k = 0; k < 2048; k++) begin
      int a, b, bin;
      a = order[k] & 31; b = (order[k] >> 5) & 31; bin = (order[k] >> 10) & 1;
      exp_r = ref_sub(a, b, bin);
      run_op(5'(a), 5'(b), 1'(bin), lat, bc, fd, mv);
      n_total++;
      if (lat !== 5 || {Overflow, Borrow, Diff} !== exp_r) begin
        if (errs < 10)
          $display("FAIL exh a=%0d b=%0d bin=%0d: got lat=%0d ov=%b bo=%b diff=%0d required 5 %b %b %0d",
                   a, b, bin, lat, Overflow, Borrow, Diff, exp_r[6], exp_r[5], exp_r[4:0]);
        errs++;
      end else n_pass++;
      n_total++;
      if (fd !== prev[4:0] || mv !== 1'b0) begin
        if (errs < 10)
          $display("FAIL exh_hold a=%0d b=%0d: got first=%0d moved=%b required %0d 0",
                   a, b, fd, mv, prev[4:0]);
        errs++;
      end else n_pass++;
      prev = exp_r;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
